fpu_exec_sequencer: RTL and testbench

Upstream control stage for the FPU ALU execution element. It accepts one decoded instruction with its operands over a valid/ready handshake and holds the operands stable on the element's inputs. It starts the element by pulsing the element's reset, waits for the element's completed flag, then captures the result and offers it to register writeback over a second valid/ready handshake. It also enforces a timeout on elements that never complete.

---
 rtl/fpu_exec_sequencer_if.sv | 67 ++++++
 rtl/fpu_exec_sequencer.sv | 149 ++++++++++++++
 tb/tb_fpu_exec_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_exec_sequencer_if.sv
// Signal bundle between the FPU execution sequencer, its upstream issue stage,
// the ALU execution element and register writeback.
interface fpu_exec_sequencer_if;
    // Issue side
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [5:0]  in_inst_num;
    logic [15:0] in_const16;
    logic [4:0]  in_shift5;
    logic [25:0] in_addr26;
    logic [31:0] in_rs;
    logic [31:0] in_rt;
    logic [31:0] in_rd;
    logic [31:0] in_fs;
    logic [31:0] in_ft;
    logic [31:0] in_fd;
    logic [4:0]  in_dest_idx;
    logic        in_dest_fpr;

    // Element side
    logic        elem_reset;
    logic        elem_completed;
    logic [31:0] elem_pc;
    logic [5:0]  elem_inst_num;
    logic [15:0] elem_const16;
    logic [4:0]  elem_shift5;
    logic [25:0] elem_addr26;
    logic [31:0] elem_rs;
    logic [31:0] elem_rt;
    logic [31:0] elem_rd;
    logic [31:0] elem_fs;
    logic [31:0] elem_ft;
    logic [31:0] elem_fd;
    logic [31:0] elem_out;

    // Writeback side
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_idx;
    logic        wb_fpr;

    // Status
    logic        busy;
    logic        timeout_err;

    modport slave (
        input  in_valid, in_pc, in_inst_num, in_const16, in_shift5, in_addr26,
               in_rs, in_rt, in_rd, in_fs, in_ft, in_fd, in_dest_idx, in_dest_fpr,
               elem_completed, elem_out, wb_ready,
        output in_ready, elem_reset,
               elem_pc, elem_inst_num, elem_const16, elem_shift5, elem_addr26,
               elem_rs, elem_rt, elem_rd, elem_fs, elem_ft, elem_fd,
               wb_valid, wb_data, wb_idx, wb_fpr, busy, timeout_err
    );

    modport master (
        output in_valid, in_pc, in_inst_num, in_const16, in_shift5, in_addr26,
               in_rs, in_rt, in_rd, in_fs, in_ft, in_fd, in_dest_idx, in_dest_fpr,
               elem_completed, elem_out, wb_ready,
        input  in_ready, elem_reset,
               elem_pc, elem_inst_num, elem_const16, elem_shift5, elem_addr26,
               elem_rs, elem_rt, elem_rd, elem_fs, elem_ft, elem_fd,
               wb_valid, wb_data, wb_idx, wb_fpr, busy, timeout_err
    );
endinterface

// File: rtl/fpu_exec_sequencer.sv
// Issue/complete/writeback sequencer for the FPU ALU execution element:
// latches one instruction, strobes the element, waits (with timeout), writes back.
module fpu_exec_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    fpu_exec_sequencer_if.slave  bus,
    output logic [1:0]           o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout_err;

    logic [31:0] r_pc;
    logic [5:0]  r_inst_num;
    logic [15:0] r_const16;
    logic [4:0]  r_shift5;
    logic [25:0] r_addr26;
    logic [31:0] r_rs;
    logic [31:0] r_rt;
    logic [31:0] r_rd;
    logic [31:0] r_fs;
    logic [31:0] r_ft;
    logic [31:0] r_fd;

    logic [31:0] r_wb_data;
    logic [4:0]  r_wb_idx;
    logic        r_wb_fpr;

    logic w_in_ready;
    logic w_accept;

    // Both handshakes transfer on a cycle where valid and ready are high
    // together; a valid side holds its payload stable until that cycle.
    // Accepting in WB only when writeback drains lets a new issue overlap the
    // outgoing result without a bubble.
    assign w_in_ready = (r_state == ST_IDLE) || ((r_state == ST_WB) && bus.wb_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
            r_pc          <= '0;
            r_inst_num    <= '0;
            r_const16     <= '0;
            r_shift5      <= '0;
            r_addr26      <= '0;
            r_rs          <= '0;
            r_rt          <= '0;
            r_rd          <= '0;
            r_fs          <= '0;
            r_ft          <= '0;
            r_fd          <= '0;
            r_wb_data     <= '0;
            r_wb_idx      <= '0;
            r_wb_fpr      <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;

            if (w_accept) begin
                r_pc       <= bus.in_pc;
                r_inst_num <= bus.in_inst_num;
                r_const16  <= bus.in_const16;
                r_shift5   <= bus.in_shift5;
                r_addr26   <= bus.in_addr26;
                r_rs       <= bus.in_rs;
                r_rt       <= bus.in_rt;
                r_rd       <= bus.in_rd;
                r_fs       <= bus.in_fs;
                r_ft       <= bus.in_ft;
                r_fd       <= bus.in_fd;
                r_wb_idx   <= bus.in_dest_idx;
                r_wb_fpr   <= bus.in_dest_fpr;
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_state <= ST_START;
                    end
                end
                // The completed flag may still be high from the previous
                // operation here, so it is deliberately not looked at.
                ST_START: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.elem_completed) begin
                        r_wb_data <= bus.elem_out;
                        r_state   <= ST_WB;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WB: begin
                    if (bus.wb_ready) begin
                        r_state <= bus.in_valid ? ST_START : ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Element strobe also covers global reset so the element never runs unsupervised.
    assign bus.elem_reset    = reset || (r_state == ST_START);
    assign bus.in_ready      = w_in_ready;

    assign bus.elem_pc       = r_pc;
    assign bus.elem_inst_num = r_inst_num;
    assign bus.elem_const16  = r_const16;
    assign bus.elem_shift5   = r_shift5;
    assign bus.elem_addr26   = r_addr26;
    assign bus.elem_rs       = r_rs;
    assign bus.elem_rt       = r_rt;
    assign bus.elem_rd       = r_rd;
    assign bus.elem_fs       = r_fs;
    assign bus.elem_ft       = r_ft;
    assign bus.elem_fd       = r_fd;

    assign bus.wb_valid      = (r_state == ST_WB);
    assign bus.wb_data       = r_wb_data;
    assign bus.wb_idx        = r_wb_idx;
    assign bus.wb_fpr        = r_wb_fpr;

    assign bus.busy          = (r_state != ST_IDLE);
    assign bus.timeout_err   = r_timeout_err;

    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_fpu_exec_sequencer.sv
// Directed bench for fpu_exec_sequencer: behavioural element model, writeback
// scoreboard, and per-cycle protocol checks.
module tb_fpu_exec_sequencer;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_WB    = 2'd3;

    logic       clk;
    logic       reset;
    logic [1:0] dbg;

    fpu_exec_sequencer_if bus ();

    fpu_exec_sequencer #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Element model: completes elem_delay clock edges after release (0 = never).
    // The result doubles a normal single-precision fs by bumping its exponent.
    int   elem_delay;
    int   e_cnt;
    logic e_done;
    logic stale_force;

    always @(posedge clk) begin
        if (bus.elem_reset) begin
            e_cnt  <= 0;
            e_done <= 1'b0;
        end else if (!e_done && elem_delay != 0) begin
            if (e_cnt + 1 >= elem_delay) e_done <= 1'b1;
            e_cnt <= e_cnt + 1;
        end
    end

    assign bus.elem_completed = e_done || stale_force;
    assign bus.elem_out       = bus.elem_fs + 32'h0080_0000;

    // Scoreboard
    logic [37:0] exp_q[$];
    int n_checks;
    int n_fail;
    int n_timeouts;
    int n_wb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.timeout_err) n_timeouts++;
            if (bus.wb_valid || bus.in_ready)
                chk("handshake_overlap", {63'd0, bus.in_ready && bus.wb_valid && !bus.wb_ready}, 64'd0);
            if (bus.wb_valid && bus.wb_ready) begin
                n_wb++;
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", 64'd1, 64'd0);
                end else begin
                    logic [37:0] e;
                    e = exp_q.pop_front();
                    chk("wb_result", {26'd0, bus.wb_data, bus.wb_idx, bus.wb_fpr}, {26'd0, e});
                end
            end
        end
    end

    // Driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] fs,
                         input logic [4:0] idx, input logic fpr, input bit expect_wb);
        bus.in_valid    = 1'b1;
        bus.in_pc       = pc;
        bus.in_fs       = fs;
        bus.in_dest_idx = idx;
        bus.in_dest_fpr = fpr;
        bus.in_inst_num = 6'($urandom_range(0, 63));
        bus.in_rs       = $urandom;
        if (expect_wb) exp_q.push_back({fs + 32'h0080_0000, idx, fpr});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0; n_fail = 0; n_timeouts = 0; n_wb = 0;
        elem_delay = 1; stale_force = 1'b0;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_inst_num = '0; bus.in_const16 = '0;
        bus.in_shift5 = '0; bus.in_addr26 = '0; bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0;
        bus.in_fs = '0; bus.in_ft = '0; bus.in_fd = '0; bus.in_dest_idx = '0; bus.in_dest_fpr = 1'b0;
        bus.wb_ready = 1'b0;

        // Reset state
        cyc(); cyc();
        look();
        chk("rst_elem_reset", {63'd0, bus.elem_reset}, 64'd1);
        chk("rst_wb_valid", {63'd0, bus.wb_valid}, 64'd0);
        cyc(); reset = 1'b0;
        look();
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_elem_reset_low", {63'd0, bus.elem_reset}, 64'd0);
        chk("rst_wb_data", {32'd0, bus.wb_data}, 64'd0);
        chk("rst_elem_fs", {32'd0, bus.elem_fs}, 64'd0);
        chk("rst_timeout", {63'd0, bus.timeout_err}, 64'd0);

        // Minimum latency: T0 accept .. T4 writeback
        cyc(); issue(32'h40, 32'h3f80_0000, 5'd5, 1'b1, 1'b1);
        look();
        chk("t0_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("t0_elem_reset", {63'd0, bus.elem_reset}, 64'd0);
        cyc(); bus.in_valid = 1'b0;
        look();
        chk("t1_elem_reset", {63'd0, bus.elem_reset}, 64'd1);
        chk("t1_state", {62'd0, dbg}, {62'd0, S_START});
        chk("t1_elem_fs", {32'd0, bus.elem_fs}, 64'h3f80_0000);
        cyc(); look();
        chk("t2_elem_reset", {63'd0, bus.elem_reset}, 64'd0);
        chk("t2_state", {62'd0, dbg}, {62'd0, S_WAIT});
        chk("t2_wb_valid", {63'd0, bus.wb_valid}, 64'd0);
        cyc(); look();
        chk("t3_state", {62'd0, dbg}, {62'd0, S_WAIT});
        chk("t3_wb_valid", {63'd0, bus.wb_valid}, 64'd0);
        cyc(); look();
        chk("t4_wb_valid", {63'd0, bus.wb_valid}, 64'd1);
        chk("t4_wb_data", {32'd0, bus.wb_data}, 64'h4000_0000);
        chk("t4_wb_idx", {59'd0, bus.wb_idx}, 64'd5);
        chk("t4_wb_fpr", {63'd0, bus.wb_fpr}, 64'd1);

        // Writeback stall with churning inputs
        for (int i = 0; i < 10; i++) begin
            cyc();
            bus.in_valid    = 1'b1;
            bus.in_pc       = $urandom;
            bus.in_fs       = $urandom;
            bus.in_dest_idx = 5'($urandom_range(0, 31));
            bus.in_dest_fpr = 1'($urandom_range(0, 1));
            look();
            chk("stall_wb_data", {32'd0, bus.wb_data}, 64'h4000_0000);
            chk("stall_wb_idx", {59'd0, bus.wb_idx}, 64'd5);
            chk("stall_wb_fpr", {63'd0, bus.wb_fpr}, 64'd1);
            chk("stall_elem_fs", {32'd0, bus.elem_fs}, 64'h3f80_0000);
            chk("stall_elem_pc", {32'd0, bus.elem_pc}, 64'h40);
            chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
            chk("stall_busy", {63'd0, bus.busy}, 64'd1);
        end

        // Back-to-back issue from WB
        cyc(); bus.wb_ready = 1'b1; issue(32'h100, 32'h4040_0000, 5'd9, 1'b0, 1'b1);
        look();
        chk("b2b_in_ready", {63'd0, bus.in_ready}, 64'd1);
        cyc(); bus.in_valid = 1'b0; bus.wb_ready = 1'b0;
        look();
        chk("b2b_state", {62'd0, dbg}, {62'd0, S_START});
        chk("b2b_elem_pc", {32'd0, bus.elem_pc}, 64'h100);
        chk("b2b_busy", {63'd0, bus.busy}, 64'd1);
        chk("b2b_elem_reset", {63'd0, bus.elem_reset}, 64'd1);
        cyc(); look();
        chk("b2b_t2_state", {62'd0, dbg}, {62'd0, S_WAIT});
        cyc(); cyc(); look();
        chk("b2b_wb_valid", {63'd0, bus.wb_valid}, 64'd1);
        chk("b2b_wb_data", {32'd0, bus.wb_data}, 64'h40c0_0000);
        cyc(); bus.wb_ready = 1'b1;
        look();
        cyc(); bus.wb_ready = 1'b0;
        look();
        chk("drain_state", {62'd0, dbg}, {62'd0, S_IDLE});
        chk("drain_wb_valid", {63'd0, bus.wb_valid}, 64'd0);

        // Stale completion held high during START
        elem_delay = 3;
        cyc(); issue(32'h200, 32'h3fc0_0000, 5'd2, 1'b1, 1'b1);
        cyc(); bus.in_valid = 1'b0; stale_force = 1'b1;
        look();
        chk("stale_start_state", {62'd0, dbg}, {62'd0, S_START});
        cyc(); stale_force = 1'b0;
        look();
        chk("stale_t2_state", {62'd0, dbg}, {62'd0, S_WAIT});
        chk("stale_t2_wb_valid", {63'd0, bus.wb_valid}, 64'd0);
        cyc(); cyc(); cyc(); look();
        chk("stale_t5_state", {62'd0, dbg}, {62'd0, S_WAIT});
        cyc(); look();
        chk("stale_wb_valid", {63'd0, bus.wb_valid}, 64'd1);
        chk("stale_wb_data", {32'd0, bus.wb_data}, 64'h4040_0000);
        cyc(); bus.wb_ready = 1'b1;
        cyc(); bus.wb_ready = 1'b0;

        // Timeout: element never completes, 8 WAIT cycles allowed
        elem_delay = 0;
        cyc(); issue(32'h300, 32'h1234_5678, 5'd7, 1'b0, 1'b0);
        cyc(); bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(); look();
            chk("to_wait_state", {62'd0, dbg}, {62'd0, S_WAIT});
            chk("to_wait_err", {63'd0, bus.timeout_err}, 64'd0);
            chk("to_wait_wb_valid", {63'd0, bus.wb_valid}, 64'd0);
        end
        cyc(); look();
        chk("to_err_pulse", {63'd0, bus.timeout_err}, 64'd1);
        chk("to_idle_state", {62'd0, dbg}, {62'd0, S_IDLE});
        chk("to_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("to_wb_valid", {63'd0, bus.wb_valid}, 64'd0);
        cyc(); look();
        chk("to_err_cleared", {63'd0, bus.timeout_err}, 64'd0);

        // Completion on the last allowed WAIT cycle wins over timeout
        elem_delay = 7;
        cyc(); issue(32'h400, 32'h4100_0000, 5'd31, 1'b0, 1'b1);
        cyc(); bus.in_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cyc(); look();
            chk("late_wait_state", {62'd0, dbg}, {62'd0, S_WAIT});
        end
        cyc(); look();
        chk("late_completed", {63'd0, bus.elem_completed}, 64'd1);
        chk("late_state", {62'd0, dbg}, {62'd0, S_WAIT});
        cyc(); look();
        chk("late_wb_valid", {63'd0, bus.wb_valid}, 64'd1);
        chk("late_no_err", {63'd0, bus.timeout_err}, 64'd0);
        chk("late_wb_data", {32'd0, bus.wb_data}, 64'h4180_0000);
        cyc(); bus.wb_ready = 1'b1;
        cyc(); bus.wb_ready = 1'b0;

        // Reset during WAIT
        elem_delay = 0;
        cyc(); issue(32'h500, 32'h4000_0000, 5'd3, 1'b1, 1'b0);
        cyc(); bus.in_valid = 1'b0;
        cyc(); cyc(); look();
        chk("rw_pre_state", {62'd0, dbg}, {62'd0, S_WAIT});
        cyc(); reset = 1'b1;
        cyc(); look();
        chk("rw_wb_valid", {63'd0, bus.wb_valid}, 64'd0);
        chk("rw_busy", {63'd0, bus.busy}, 64'd0);
        chk("rw_elem_reset", {63'd0, bus.elem_reset}, 64'd1);
        chk("rw_no_err", {63'd0, bus.timeout_err}, 64'd0);
        cyc(); reset = 1'b0;
        look();
        chk("rw_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rw_elem_fs", {32'd0, bus.elem_fs}, 64'd0);
        for (int i = 0; i < 10; i++) begin
            cyc(); look();
        end

        // End-of-run bookkeeping
        chk("sb_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("wb_count", 64'(n_wb), 64'd4);
        chk("timeout_count", 64'(n_timeouts), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
